// File: rtl/ar_fifo_pkg.sv
// Shared types and constants for the AR arbiter and its FIFO-side payload.
// The AR request struct is packed MSB-first to match the 49-bit FIFO word.
package ar_fifo_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int MASTER_ID_W = 4;
    localparam int SLAVE_ID_W  = 8;

    typedef struct packed {
        logic [SLAVE_ID_W-1:0] id;
        logic [31:0]           addr;
        logic [3:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } ar_req_t;

    localparam int AR_REQ_W = $bits(ar_req_t);

    typedef enum logic {
        IDLE = 1'b0,
        PUSH = 1'b1
    } state_t;

endpackage

// File: rtl/ar_fifo_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: when both request, the one not granted last wins.
// Pure combinational; the caller owns the last-grant register.
module rr_arbiter2
    import ar_fifo_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic                   i_last_grant,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic                   o_grant_idx,
    output logic                   o_valid
);

    always_comb begin
        o_grant_idx = 1'b0;
        o_valid     = |i_req;
        if (&i_req) begin
            o_grant_idx = ~i_last_grant;
        end else if (i_req[1]) begin
            o_grant_idx = 1'b1;
        end
        o_grant = 2'b00;
        if (o_valid) begin
            o_grant = o_grant_idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ar_fifo_arbiter.sv
// Two-master AXI AR arbiter feeding the AR clock-crossing FIFO write side.
// One staging register, per-master outstanding-burst caps, round-robin grant.
//
// state | meaning
// IDLE  | staging empty, accept straight into staging
// PUSH  | staging full, pushing to FIFO; reload on the same drain cycle
module ar_fifo_arbiter
    import ar_fifo_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] arvalid_m,
    output logic [NUM_MASTERS-1:0] arready_m,
    input  logic [MASTER_ID_W-1:0] arid_m0,
    input  logic [MASTER_ID_W-1:0] arid_m1,
    input  logic [31:0]            araddr_m0,
    input  logic [31:0]            araddr_m1,
    input  logic [3:0]             arlen_m0,
    input  logic [3:0]             arlen_m1,
    input  logic [2:0]             arsize_m0,
    input  logic [2:0]             arsize_m1,
    input  logic [1:0]             arburst_m0,
    input  logic [1:0]             arburst_m1,
    output logic                   fifo_wpush,
    output logic [AR_REQ_W-1:0]    fifo_wdata,
    input  logic                   fifo_wfull,
    input  logic                   rdone,
    input  logic                   rdone_master,
    output logic                   busy
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    ar_req_t                  r_stage;
    ar_req_t                  w_win_req;
    logic                     r_last_grant;
    logic [CNT_W-1:0]         r_cnt [NUM_MASTERS];

    logic [NUM_MASTERS-1:0]   w_elig;
    logic [NUM_MASTERS-1:0]   w_grant;
    logic                     w_grant_idx;
    logic                     w_any;
    logic                     w_accept;
    logic                     w_drain;
    logic [NUM_MASTERS-1:0]   w_inc;
    logic [NUM_MASTERS-1:0]   w_dec;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_elig[i] = arvalid_m[i] && (r_cnt[i] < CNT_W'(MAX_OUTSTANDING));
        end
    end

    rr_arbiter2 u_rr (
        .i_req        (w_elig),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_valid      (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drain     = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = w_any;
                if (w_accept) begin
                    w_state_nxt = PUSH;
                end
            end
            PUSH: begin
                w_drain  = ~fifo_wfull;
                w_accept = w_drain && w_any;
                if (w_drain && !w_accept) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Upper ID bits carry the master index so the R path can route responses back.
    always_comb begin
        w_win_req = '0;
        if (w_grant_idx) begin
            w_win_req.id    = {3'b000, 1'b1, arid_m1};
            w_win_req.addr  = araddr_m1;
            w_win_req.len   = arlen_m1;
            w_win_req.size  = arsize_m1;
            w_win_req.burst = arburst_m1;
        end else begin
            w_win_req.id    = {3'b000, 1'b0, arid_m0};
            w_win_req.addr  = araddr_m0;
            w_win_req.len   = arlen_m0;
            w_win_req.size  = arsize_m0;
            w_win_req.burst = arburst_m0;
        end
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_inc[i] = w_accept && (w_grant_idx == 1'(i));
            w_dec[i] = rdone && (rdone_master == 1'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_stage      <= '0;
            r_last_grant <= 1'b1;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_stage      <= w_win_req;
                r_last_grant <= w_grant_idx;
            end
            // Simultaneous accept and completion leave the count unchanged; underflow saturates.
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign arready_m  = w_accept ? w_grant : '0;
    assign fifo_wpush = (r_state == PUSH);
    assign busy       = (r_state == PUSH);
    assign fifo_wdata = fifo_wpush ? r_stage : '0;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                assert (!(w_dec[i] && !w_inc[i] && (r_cnt[i] == '0)))
                    else $error("ar_fifo_arbiter: rdone for master %0d with no bursts outstanding", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ar_fifo_arbiter.sv
// Directed bench for ar_fifo_arbiter: grant order, staging/push timing,
// back-pressure, outstanding caps and reset recovery.
module tb_ar_fifo_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  arvalid_m;
    logic [1:0]  arready_m;
    logic [3:0]  arid_m0, arid_m1;
    logic [31:0] araddr_m0, araddr_m1;
    logic [3:0]  arlen_m0, arlen_m1;
    logic [2:0]  arsize_m0, arsize_m1;
    logic [1:0]  arburst_m0, arburst_m1;
    logic        fifo_wpush;
    logic [48:0] fifo_wdata;
    logic        fifo_wfull;
    logic        rdone;
    logic        rdone_master;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [48:0] REQ_M0   = {8'h03, 32'h0000_1000, 4'h3, 3'h2, 2'h1};
    localparam logic [48:0] REQ_M1   = {8'h15, 32'h0000_2000, 4'h7, 3'h3, 2'h1};

    always #5 clk = ~clk;

    ar_fifo_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .arvalid_m    (arvalid_m),
        .arready_m    (arready_m),
        .arid_m0      (arid_m0),
        .arid_m1      (arid_m1),
        .araddr_m0    (araddr_m0),
        .araddr_m1    (araddr_m1),
        .arlen_m0     (arlen_m0),
        .arlen_m1     (arlen_m1),
        .arsize_m0    (arsize_m0),
        .arsize_m1    (arsize_m1),
        .arburst_m0   (arburst_m0),
        .arburst_m1   (arburst_m1),
        .fifo_wpush   (fifo_wpush),
        .fifo_wdata   (fifo_wdata),
        .fifo_wfull   (fifo_wfull),
        .rdone        (rdone),
        .rdone_master (rdone_master),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let inputs be changed.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        arvalid_m = 2'b00;
        arid_m0 = 4'h3;  araddr_m0 = 32'h0000_1000; arlen_m0 = 4'h3; arsize_m0 = 3'h2; arburst_m0 = 2'h1;
        arid_m1 = 4'h5;  araddr_m1 = 32'h0000_2000; arlen_m1 = 4'h7; arsize_m1 = 3'h3; arburst_m1 = 2'h1;
        fifo_wfull = 1'b0;
        rdone = 1'b0;
        rdone_master = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        settle();
        check("rst_wpush", 64'(fifo_wpush), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_arready", 64'(arready_m), 64'd0);
        check("rst_wdata", 64'(fifo_wdata), 64'd0);
        check("rst_cnt0", 64'(dut.r_cnt[0]), 64'd0);
        check("rst_cnt1", 64'(dut.r_cnt[1]), 64'd0);

        // Single M0 request: same-cycle ready, push one cycle later.
        next_cycle();
        arvalid_m = 2'b01;
        settle();
        check("m0_arready", 64'(arready_m), 64'h1);
        next_cycle();
        arvalid_m = 2'b00;
        settle();
        check("m0_wpush", 64'(fifo_wpush), 64'd1);
        check("m0_id", 64'(fifo_wdata[48:41]), 64'h03);
        check("m0_addr", 64'(fifo_wdata[40:9]), 64'h1000);
        check("m0_wdata", 64'(fifo_wdata), 64'(REQ_M0));
        check("m0_cnt0", 64'(dut.r_cnt[0]), 64'd1);
        next_cycle();
        settle();
        check("m0_drained", 64'(fifo_wpush), 64'd0);

        // Both valid: M0 won last, so M1 first, then alternate, one push per cycle.
        arvalid_m = 2'b11;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("alt_arready", 64'(arready_m), (i % 2 == 0) ? 64'h2 : 64'h1);
            if (i > 0) begin
                check("alt_wpush", 64'(fifo_wpush), 64'd1);
                check("alt_id", 64'(fifo_wdata[48:41]), (i % 2 == 1) ? 64'h15 : 64'h03);
            end
            next_cycle();
        end
        arvalid_m = 2'b00;
        settle();
        check("alt_last_id", 64'(fifo_wdata[48:41]), 64'h03);
        check("alt_cnt0", 64'(dut.r_cnt[0]), 64'd3);
        check("alt_cnt1", 64'(dut.r_cnt[1]), 64'd2);
        next_cycle();

        // Back-pressure: staged M1 held for 5 full cycles, then drain+accept together.
        arvalid_m = 2'b10;
        settle();
        check("bp_accept_m1", 64'(arready_m), 64'h2);
        next_cycle();
        arvalid_m  = 2'b11;
        fifo_wfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("bp_wpush", 64'(fifo_wpush), 64'd1);
            check("bp_wdata", 64'(fifo_wdata), 64'(REQ_M1));
            check("bp_arready", 64'(arready_m), 64'h0);
            check("bp_busy", 64'(busy), 64'd1);
            next_cycle();
        end
        fifo_wfull = 1'b0;
        settle();
        check("bp_release_arready", 64'(arready_m), 64'h1);
        check("bp_release_wdata", 64'(fifo_wdata), 64'(REQ_M1));
        next_cycle();
        arvalid_m = 2'b00;
        settle();
        check("bp_reload_wdata", 64'(fifo_wdata), 64'(REQ_M0));
        check("bp_cnt0", 64'(dut.r_cnt[0]), 64'd4);
        next_cycle();

        // Two M0 completions bring cnt0 from 4 to 2.
        rdone = 1'b1;
        rdone_master = 1'b0;
        next_cycle();
        next_cycle();
        rdone = 1'b0;
        settle();
        check("rdone_cnt0", 64'(dut.r_cnt[0]), 64'd2);

        // Accept and completion for M0 in the same cycle leave cnt0 unchanged.
        arvalid_m = 2'b01;
        rdone = 1'b1;
        rdone_master = 1'b0;
        settle();
        check("same_arready", 64'(arready_m), 64'h1);
        next_cycle();
        arvalid_m = 2'b00;
        rdone = 1'b0;
        settle();
        check("same_cnt0", 64'(dut.r_cnt[0]), 64'd2);
        next_cycle();

        // M1 reaches its cap of 4; M0 still granted, M1 blocked until a completion.
        arvalid_m = 2'b10;
        settle();
        check("cap_4th_m1", 64'(arready_m), 64'h2);
        next_cycle();
        arvalid_m = 2'b11;
        settle();
        check("cap_cnt1", 64'(dut.r_cnt[1]), 64'd4);
        check("cap_m0_only", 64'(arready_m), 64'h1);
        next_cycle();
        arvalid_m = 2'b10;
        rdone = 1'b1;
        rdone_master = 1'b1;
        settle();
        check("cap_m1_blocked", 64'(arready_m), 64'h0);
        next_cycle();
        rdone = 1'b0;
        settle();
        check("cap_m1_reaccept", 64'(arready_m), 64'h2);
        next_cycle();
        arvalid_m = 2'b00;
        settle();
        check("cap_cnt1_after", 64'(dut.r_cnt[1]), 64'd4);
        check("cap_push_m1", 64'(fifo_wdata), 64'(REQ_M1));

        // Reset while stalled with a staged request.
        fifo_wfull = 1'b1;
        next_cycle();
        settle();
        check("pre_rst_wpush", 64'(fifo_wpush), 64'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        fifo_wfull = 1'b0;
        settle();
        check("mid_rst_wpush", 64'(fifo_wpush), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cnt0", 64'(dut.r_cnt[0]), 64'd0);
        check("mid_rst_cnt1", 64'(dut.r_cnt[1]), 64'd0);
        arvalid_m = 2'b11;
        settle();
        check("post_rst_grant_m0", 64'(arready_m), 64'h1);
        next_cycle();
        arvalid_m = 2'b00;
        next_cycle();
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ar_fifo_arbiter.md
Name: ar_fifo_arbiter

Overview:
- Two-master AXI read-address (AR) arbiter in the AXI clock domain; sole producer on the write side of the 49-bit AR clock-domain-crossing FIFO toward the slave.
- Round-robin arbitration between M0 (instruction fetch) and M1 (data); tags the winner's ID with the master index.
- Holds one accepted request in a staging register and pushes it into the FIFO when not full.
- Caps read bursts outstanding per master; counts them down on R-last completions returned from the slave side.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-uncompleted read bursts per master (1..15).
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of each outstanding counter.

Ports:
- clk  in  1  single clock (AXI domain, same as FIFO write clock)
- rst  in  1  synchronous active-high reset
- arvalid_m  in  2  per-master AR valid; bit i = master i
- arready_m  out  2  per-master AR ready
- arid_m0 / arid_m1  in  4 each  master AR ID
- araddr_m0 / araddr_m1  in  32 each  address
- arlen_m0 / arlen_m1  in  4 each  burst length
- arsize_m0 / arsize_m1  in  3 each  beat size
- arburst_m0 / arburst_m1  in  2 each  burst type
- fifo_wpush  out  1  FIFO push enable
- fifo_wdata  out  49  {arids[7:0], araddr[31:0], arlen[3:0], arsize[2:0], arburst[1:0]}, MSB first
- fifo_wfull  in  1  FIFO full
- rdone  in  1  one-cycle pulse: R handshake with RLAST=1 completed for some master
- rdone_master  in  1  master index of that completion (rid[7:4] bit 0)
- busy  out  1  staging register occupied

Behaviour:
- Reset (rst=1 at a clk edge) values: state=IDLE, arready_m=0, fifo_wpush=0, fifo_wdata=0, busy=0, both counters=0, last_grant=1 (M0 wins first).
- Eligible(i) = arvalid_m[i] && cnt[i] < MAX_OUTSTANDING.
- Arbitration (combinational): if both masters are eligible, the master != last_grant wins; if only one is eligible, it wins.
- States:
  - IDLE: accept = any eligible. arready_m is one-hot to the winner, combinational in the same cycle.
  - PUSH: fifo_wpush=1, fifo_wdata=staging, busy=1.
  - In PUSH, drain = ~fifo_wfull; accept = drain && any eligible.
- Transitions:
  - IDLE→PUSH on accept.
  - PUSH→IDLE on drain && no accept.
  - PUSH→PUSH otherwise. On drain+accept, the staging register reloads in the same cycle, giving full throughput of one burst per cycle.
- On accept:
  - staging <= {1'b0? no: 3'b000, winner, arid_winner, araddr, arlen, arsize, arburst}, i.e. arids = {3'b000, winner_idx, arid[3:0]}.
  - last_grant <= winner.
  - cnt[winner] increments.
- fifo_wpush is asserted only in PUSH and held stable with unchanged data while fifo_wfull=1. The block never deasserts a pending push without a drain.
- Latency: request accepted at edge N → fifo_wpush=1 in cycle N+1.
- Counter update per master each cycle:
  - +1 on accept for that master.
  - -1 on rdone for that master.
  - Both in the same cycle → unchanged.
  - rdone on a counter at 0 is a protocol error: the counter saturates at 0 and a simulation assertion fires.
- At cnt=MAX_OUTSTANDING the master is ineligible; its arready stays 0 until the next rdone.
- arvalid dropping before handshake: the request is simply not accepted (AXI violation, not checked in RTL).
- Reset mid-operation (staging full, FIFO full) discards the staged request; counters clear.
- The FIFO side must be reset in the same cycle by the integrator.

Decomposition:
- Shared package ar_fifo_pkg:
  - ar_req_t packed struct (id 8, addr 32, len 4, size 3, burst 2) = 49 bits.
  - NUM_MASTERS=2, MASTER_ID_W=4, SLAVE_ID_W=8.
  - state enum {IDLE, PUSH}.
- One sub-module, rr_arbiter2: 2-input round-robin grant from req[1:0] and last_grant. Counters and staging register stay in the top.

Test Plan:
- Reset, then M0 only: arvalid_m=01, araddr_m0=0x0000_1000, arid_m0=3, arlen=3, fifo_wfull=0 → arready_m=01 same cycle; next cycle fifo_wpush=1, fifo_wdata[48:41]=0x03, addr=0x1000; cnt0=1.
- Both masters valid continuously, fifo_wfull=0 → grants alternate M0,M1,M0,M1; one push per cycle; ID byte alternates 0x0X/0x1X.
- fifo_wfull=1 for 5 cycles with a request staged → fifo_wpush held 1 with constant fifo_wdata, arready_m=00. Release → push drains and a new accept occurs in the same cycle.
- M1 issues 4 bursts with no rdone (MAX=4) → 5th request sees arready_m[1]=0 while M0 is still granted. rdone=1, rdone_master=1 → M1 accepted the next cycle.
- Accept for M0 and rdone for M0 in the same cycle with cnt0=2 → cnt0 stays 2.
- Assert rst while in PUSH with fifo_wfull=1 → next cycle fifo_wpush=0, busy=0, counters=0; first post-reset grant goes to M0.
